// File: rtl/conv_line_feeder_if.sv
// -----------------------------------------------------------------------------
// conv_line_feeder_if
// Pixel-in / column-out bundle for the conv line feeder.
//   i_pix, i_valid, i_sof : raster pixel stream from the producer
//   o_ready               : feeder accepts i_pix when i_valid & o_ready
//   o_dato0..o_dato2      : rows r-1, r, r+1 of the emitted column
//   o_valid               : a column (data or pad) is present this cycle
//   o_sol, o_eof          : row-start / frame-end marks, present only when
//                           CONV_FEED_MARK_EN is defined
// Modports: slave = the feeder, master = the pixel producer / column consumer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface conv_line_feeder_if #(
  parameter int BIT_LEN = 8
);
  logic [BIT_LEN-1:0] i_pix;
  logic               i_valid;
  logic               i_sof;
  logic               o_ready;
  logic [BIT_LEN-1:0] o_dato0;
  logic [BIT_LEN-1:0] o_dato1;
  logic [BIT_LEN-1:0] o_dato2;
  logic               o_valid;
`ifdef CONV_FEED_MARK_EN
  logic               o_sol;
  logic               o_eof;
`endif

  modport slave (
    input  i_pix,
    input  i_valid,
    input  i_sof,
    output o_ready,
    output o_dato0,
    output o_dato1,
    output o_dato2,
`ifdef CONV_FEED_MARK_EN
    output o_sol,
    output o_eof,
`endif
    output o_valid
  );

  modport master (
    output i_pix,
    output i_valid,
    output i_sof,
    input  o_ready,
    input  o_dato0,
    input  o_dato1,
    input  o_dato2,
`ifdef CONV_FEED_MARK_EN
    input  o_sol,
    input  o_eof,
`endif
    input  o_valid
  );
endinterface

// File: rtl/conv_line_feeder.sv
// -----------------------------------------------------------------------------
// conv_line_feeder
// Turns a raster pixel stream into zero-padded 3-pixel columns for the 3x3
// conv core: each output column carries rows r-1 / r / r+1 at one x position,
// with one all-zero pad column on each side of every row (IMG_W+2 columns).
//
// Ports
//   i_Clk    : clock, rising edge
//   i_reset  : asynchronous, active-low reset
//   bus      : conv_line_feeder_if.slave (pixel in, column out, o_ready)
//
// Optional build macro
//   CONV_FEED_MARK_EN : adds o_sol (with column 0 of every output row) and
//                       o_eof (with the last column of the frame).
//
// Line storage: two single-port-style banks, each read and written at the same
// address in the same cycle (read returns old data). Instead of copying the
// newest row into the older buffer, the roles swap at the end of every row:
// sel_reg names the bank holding row r ("B"), the other bank holds row r-1
// ("A") and is overwritten by incoming row r+1 as A is read out.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module conv_line_feeder #(
  parameter int BIT_LEN = 8,
  parameter int IMG_W   = 415,
  parameter int IMG_H   = 415
) (
  input  logic i_Clk,
  input  logic i_reset,
  conv_line_feeder_if.slave bus
);

  localparam int FEA_SIZE = IMG_W + 2;
  localparam int CW       = $clog2(FEA_SIZE);
  localparam int AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(FEA_SIZE - 1);
  localparam logic [AW-1:0] X_LAST     = AW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST_S = RW'((IMG_H >= 2) ? (IMG_H - 2) : 0);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  state_t             state_reg;
  logic [CW-1:0]      col_reg;
  logic [RW-1:0]      row_reg;
  logic               sel_reg;
  logic               valid_reg;
  logic [BIT_LEN-1:0] dato2_reg;
  logic               lane1_en_reg;
  logic               lane0_en_reg;
  logic               bsel_out_reg;
`ifdef CONV_FEED_MARK_EN
  logic               sol_reg;
  logic               eof_reg;
`endif

  logic               ready;
  logic               accept;
  logic               sof_acc;
  logic               fill_acc;
  logic               stream_acc;
  logic [AW-1:0]      fill_x;
  logic [AW-1:0]      ram_addr;
  logic [1:0]         wr_en;
  logic [BIT_LEN-1:0] rd_data [2];

  // Pad columns (c=0, c=FEA_SIZE-1) and the whole flush row take no input.
  assign ready = (state_reg == ST_FILL) ||
                 ((state_reg == ST_STREAM) && (col_reg != '0) && (col_reg != COL_LAST));

  assign accept     = bus.i_valid & ready;
  assign sof_acc    = accept & bus.i_sof;
  // A start-of-frame pixel is handled as the first pixel of a fresh fill.
  assign fill_acc   = accept & (sof_acc | (state_reg == ST_FILL));
  assign stream_acc = accept & ~sof_acc & (state_reg == ST_STREAM);

  // In FILL the column counter is the pixel's x; in STREAM/FLUSH it is x+1.
  assign fill_x   = sof_acc ? '0 : col_reg[AW-1:0];
  assign ram_addr = fill_acc ? fill_x : AW'(col_reg - CW'(1));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [BIT_LEN-1:0] mem [IMG_W];
      logic [BIT_LEN-1:0] rd_q;

      // Row 0 fills the B bank; streamed rows overwrite the A bank.
      assign wr_en[gi] = (fill_acc & (sel_reg == 1'(gi))) |
                         (stream_acc & (sel_reg != 1'(gi)));

      always_ff @(posedge i_Clk) begin
        rd_q <= mem[ram_addr];
        if (wr_en[gi]) begin
          mem[ram_addr] <= bus.i_pix;
        end
      end

      assign rd_data[gi] = rd_q;
    end
  endgenerate

  always_ff @(posedge i_Clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg    <= ST_FILL;
      col_reg      <= '0;
      row_reg      <= '0;
      sel_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      dato2_reg    <= '0;
      lane1_en_reg <= 1'b0;
      lane0_en_reg <= 1'b0;
      bsel_out_reg <= 1'b0;
`ifdef CONV_FEED_MARK_EN
      sol_reg      <= 1'b0;
      eof_reg      <= 1'b0;
`endif
    end else begin
      // Idle / pad defaults: no column, all lanes zero.
      valid_reg    <= 1'b0;
      dato2_reg    <= '0;
      lane1_en_reg <= 1'b0;
      lane0_en_reg <= 1'b0;
`ifdef CONV_FEED_MARK_EN
      sol_reg      <= 1'b0;
      eof_reg      <= 1'b0;
`endif
      if (fill_acc) begin
        row_reg <= '0;
        if (fill_x == X_LAST) begin
          col_reg   <= '0;
          state_reg <= (IMG_H == 1) ? ST_FLUSH : ST_STREAM;
        end else begin
          col_reg   <= CW'(fill_x) + CW'(1);
          state_reg <= ST_FILL;
        end
      end else begin
        case (state_reg)
          ST_STREAM: begin
            if (col_reg == '0) begin
              valid_reg <= 1'b1;
`ifdef CONV_FEED_MARK_EN
              sol_reg   <= 1'b1;
`endif
              col_reg   <= CW'(1);
            end else if (col_reg == COL_LAST) begin
              valid_reg <= 1'b1;
              col_reg   <= '0;
              sel_reg   <= ~sel_reg;
              if (row_reg == ROW_LAST_S) begin
                state_reg <= ST_FLUSH;
              end else begin
                row_reg <= row_reg + RW'(1);
              end
            end else if (stream_acc) begin
              valid_reg    <= 1'b1;
              dato2_reg    <= bus.i_pix;
              lane1_en_reg <= 1'b1;
              lane0_en_reg <= (row_reg != '0);
              bsel_out_reg <= sel_reg;
              col_reg      <= col_reg + CW'(1);
            end
          end
          ST_FLUSH: begin
            valid_reg <= 1'b1;
`ifdef CONV_FEED_MARK_EN
            sol_reg   <= (col_reg == '0);
`endif
            if (col_reg == COL_LAST) begin
`ifdef CONV_FEED_MARK_EN
              eof_reg   <= 1'b1;
`endif
              col_reg   <= '0;
              state_reg <= ST_FILL;
            end else begin
              if (col_reg != '0) begin
                lane1_en_reg <= 1'b1;
                lane0_en_reg <= (IMG_H > 1);
                bsel_out_reg <= sel_reg;
              end
              col_reg <= col_reg + CW'(1);
            end
          end
          default: begin
            // ST_FILL without an accepted pixel: hold.
          end
        endcase
      end
    end
  end

  // Lane enables are cleared by reset, so unreset RAM read data never leaks.
  assign bus.o_ready = ready;
  assign bus.o_valid = valid_reg;
  assign bus.o_dato2 = dato2_reg;
  assign bus.o_dato1 = lane1_en_reg ? rd_data[bsel_out_reg]  : '0;
  assign bus.o_dato0 = lane0_en_reg ? rd_data[~bsel_out_reg] : '0;
`ifdef CONV_FEED_MARK_EN
  assign bus.o_sol   = sol_reg;
  assign bus.o_eof   = eof_reg;
`endif

endmodule

// File: tb/tb_conv_line_feeder.sv
// -----------------------------------------------------------------------------
// tb_conv_line_feeder
// Directed scenarios with random pixel data for conv_line_feeder at
// IMG_W=4, IMG_H=3. Expected columns come from the 3x3 window definition
// applied to the frame image held in the bench.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_conv_line_feeder;
  localparam int BIT_LEN = 8;
  localparam int IMG_W   = 4;
  localparam int IMG_H   = 3;
  localparam int FEA     = IMG_W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  conv_line_feeder_if #(.BIT_LEN(BIT_LEN)) bus();

  conv_line_feeder #(
    .BIT_LEN(BIT_LEN),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) dut (
    .i_Clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [7:0]  img [IMG_H][IMG_W];
  logic [23:0] exp_q[$];
  logic [23:0] got[$];
  int          got_cyc[$];
`ifdef CONV_FEED_MARK_EN
  logic [1:0]  got_mark[$];
`endif

  // Column monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      got.push_back({bus.o_dato0, bus.o_dato1, bus.o_dato2});
      got_cyc.push_back(cycle);
`ifdef CONV_FEED_MARK_EN
      got_mark.push_back({bus.o_sol, bus.o_eof});
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: column (r,c) = rows r-1,r,r+1 at x=c-1, zero outside the image.
  task automatic build_exp();
    logic [7:0] top, mid, bot;
    exp_q.delete();
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < FEA; c++) begin
        if (c == 0 || c == FEA - 1) begin
          exp_q.push_back(24'h0);
        end else begin
          top = (r > 0) ? img[r-1][c-1] : 8'h0;
          mid = img[r][c-1];
          bot = (r < IMG_H - 1) ? img[r+1][c-1] : 8'h0;
          exp_q.push_back({top, mid, bot});
        end
      end
    end
  endtask

  task automatic fill_img(input bit rnd);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = rnd ? 8'($urandom) : 8'(10 * r + c + 1);
  endtask

  bit         pend = 1'b0;
  logic [7:0] pend_pix;
  bit         alt = 1'b0;

  // A pixel of input row >= 1 must appear on the bottom lane one cycle later.
  task automatic check_pending();
    if (pend) begin
      check("latency", 32'({bus.o_valid, bus.o_dato2}), 32'({1'b1, pend_pix}));
      pend = 1'b0;
    end
  endtask

  // mode 0: valid every cycle, 1: every other cycle, 2: random gaps
  task automatic send_pix(input logic [7:0] p, input bit sof, input int mode, input bit bot);
    bit done = 1'b0;
    bit v;
    bit rdy;
    int tries = 0;
    while (!done) begin
      @(negedge clk);
      check_pending();
      case (mode)
        0:       v = 1'b1;
        1:       begin v = alt; alt = ~alt; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.i_valid = v;
      bus.i_pix   = v ? p : 8'($urandom);
      bus.i_sof   = v & sof;
      rdy = bus.o_ready;
      @(posedge clk);
      if (v && rdy) begin
        done = 1'b1;
      end else begin
        tries++;
        if (tries > 50) begin
          check("accept_timeout", 32'(tries), 32'(0));
          done = 1'b1;
        end
      end
    end
    #1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    pend     = bot;
    pend_pix = p;
  endtask

  task automatic send_frame(input int mode, input bit first_sof);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        send_pix(img[r][c], first_sof && r == 0 && c == 0, mode, r > 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_pending();
    end
  endtask

  task automatic compare_out(input string tag, input int n);
    check({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      check($sformatf("%s_col%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
`ifdef CONV_FEED_MARK_EN
      check($sformatf("%s_mark%0d", tag, i), 32'(got_mark[i]),
            32'({(i % FEA) == 0, i == IMG_H * FEA - 1}));
`endif
    end
    got.delete();
    got_cyc.delete();
`ifdef CONV_FEED_MARK_EN
    got_mark.delete();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_pix   = '0;

    // 1: reset, then idle with no input
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("in_reset_valid", 32'(bus.o_valid), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i),
            32'({bus.o_valid, bus.o_dato0, bus.o_dato1, bus.o_dato2, bus.o_ready}), 32'(1));
    end

    // 2/3: full frame, continuous valid, no sof on first pixel after reset
    fill_img(1'b0);
    build_exp();
    send_frame(0, 1'b0);
    low = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_pending();
      if (!bus.o_ready) low++;
    end
    check("ready_low_run", 32'(low), 32'(7));
    check("s2_r0c1", 32'(got[1]), 32'({8'd0, 8'd1, 8'd11}));
    check("s2_r0c4", 32'(got[4]), 32'({8'd0, 8'd4, 8'd14}));
    check("s2_r1c1", 32'(got[7]), 32'({8'd1, 8'd11, 8'd21}));
    check("s2_fl_c1", 32'(got[13]), 32'({8'd11, 8'd21, 8'd0}));
    check("s2_fl_c4", 32'(got[16]), 32'({8'd14, 8'd24, 8'd0}));
    if (got_cyc.size() == IMG_H * FEA)
      check("s2_contiguous", 32'(got_cyc[IMG_H*FEA-1] - got_cyc[0]), 32'(IMG_H * FEA - 1));
    compare_out("frame", IMG_H * FEA);

    // 4: random data, valid every other cycle, sof on first pixel
    fill_img(1'b1);
    build_exp();
    send_frame(1, 1'b1);
    idle(12);
    if (got_cyc.size() == IMG_H * FEA) begin
      for (int r = 0; r < IMG_H - 1; r++) begin
        check($sformatf("alt_endpad%0d", r),
              32'(got_cyc[r*FEA+FEA-1] - got_cyc[r*FEA+FEA-2]), 32'(1));
        check($sformatf("alt_startpad%0d", r),
              32'(got_cyc[r*FEA+FEA] - got_cyc[r*FEA+FEA-1]), 32'(1));
      end
      check("alt_flush_run", 32'(got_cyc[IMG_H*FEA-1] - got_cyc[(IMG_H-1)*FEA]), 32'(FEA - 1));
    end
    compare_out("alt", IMG_H * FEA);

    // 5: sof with pixel 99 at row 1 col 2 aborts the frame
    fill_img(1'b1);
    build_exp();
    for (int c = 0; c < IMG_W; c++) send_pix(img[0][c], c == 0, 2, 1'b0);
    send_pix(img[1][0], 1'b0, 2, 1'b1);
    send_pix(img[1][1], 1'b0, 2, 1'b1);
    send_pix(8'd99, 1'b1, 0, 1'b0);
    idle(3);
    compare_out("abort", 3);
    fill_img(1'b1);
    img[0][0] = 8'd99;
    build_exp();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        if (r != 0 || c != 0) send_pix(img[r][c], 1'b0, 2, r > 0);
    idle(12);
    check("sof_r0c1", 32'(got[1]), 32'({8'd0, 8'd99, img[1][0]}));
    compare_out("sof_frame", IMG_H * FEA);

    // 6: async reset mid-stream, then the scenario-2 frame again
    fill_img(1'b0);
    build_exp();
    for (int c = 0; c < IMG_W; c++) send_pix(img[0][c], 1'b0, 0, 1'b0);
    send_pix(img[1][0], 1'b0, 0, 1'b1);
    send_pix(img[1][1], 1'b0, 0, 1'b1);
    check_pending();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out",
          32'({bus.o_valid, bus.o_dato0, bus.o_dato1, bus.o_dato2, bus.o_ready}), 32'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    got_cyc.delete();
`ifdef CONV_FEED_MARK_EN
    got_mark.delete();
`endif
    send_frame(0, 1'b0);
    idle(12);
    compare_out("rst_frame", IMG_H * FEA);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
